// File: rtl/muldiv_param_if.sv
// Request/result bundle between the execute stage and the muldiv_param HI/LO unit.
interface muldiv_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_param.sv
// Multi-cycle multiply/divide unit owning HI/LO with fixed latencies, flush-abort and done pulse.
// Define MULDIV_MADD_EN to enable the MADD/MSUB accumulate ops (110/111).
module muldiv_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_param_if.slave  bus
);
  localparam int MAX_C = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]       r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [WIDTH-1:0]       r_pend_hi, r_pend_lo, w_pend_hi_nxt, w_pend_lo_nxt;
  logic                   r_done, w_done_nxt;

  logic [2*WIDTH-1:0]     w_prod_s, w_prod_u;
  logic                   w_a_neg, w_b_neg, w_div_zero;
  logic [WIDTH-1:0]       w_abs_a, w_abs_b, w_div_b, w_uq, w_ur, w_div_hi, w_div_lo;

  assign w_prod_s = $signed({{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a})
                  * $signed({{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b});
  assign w_prod_u = {{WIDTH{1'b0}}, bus.src_a} * {{WIDTH{1'b0}}, bus.src_b};

  // Signed divide is done on magnitudes, so -2^(W-1) / -1 naturally yields lo=-2^(W-1), hi=0.
  assign w_a_neg    = ~bus.op[0] & bus.src_a[WIDTH-1];
  assign w_b_neg    = ~bus.op[0] & bus.src_b[WIDTH-1];
  assign w_abs_a    = w_a_neg ? (~bus.src_a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src_a;
  assign w_abs_b    = w_b_neg ? (~bus.src_b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src_b;
  assign w_div_zero = (bus.src_b == {WIDTH{1'b0}});
  assign w_div_b    = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_abs_b;
  assign w_uq       = w_abs_a / w_div_b;
  assign w_ur       = w_abs_a % w_div_b;
  assign w_div_lo   = w_div_zero ? {WIDTH{1'b1}} :
                      ((w_a_neg ^ w_b_neg) ? (~w_uq + {{(WIDTH-1){1'b0}}, 1'b1}) : w_uq);
  assign w_div_hi   = w_div_zero ? bus.src_a :
                      (w_a_neg ? (~w_ur + {{(WIDTH-1){1'b0}}, 1'b1}) : w_ur);

`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] w_acc_add, w_acc_sub;
  assign w_acc_add = {r_hi, r_lo} + w_prod_s;
  assign w_acc_sub = {r_hi, r_lo} - w_prod_s;
`endif

  // Next-state, counter, pending-result and HI/LO update logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'b000: begin
              {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
              w_cnt_nxt   = CW'(MUL_CYCLES);
              w_state_nxt = S_RUN;
            end
            3'b001: begin
              {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
              w_cnt_nxt   = CW'(MUL_CYCLES);
              w_state_nxt = S_RUN;
            end
            3'b010, 3'b011: begin
              w_pend_hi_nxt = w_div_hi;
              w_pend_lo_nxt = w_div_lo;
              w_cnt_nxt     = CW'(DIV_CYCLES);
              w_state_nxt   = S_RUN;
            end
            3'b100: w_hi_nxt = bus.src_a;
            3'b101: w_lo_nxt = bus.src_a;
`ifdef MULDIV_MADD_EN
            3'b110: begin
              {w_pend_hi_nxt, w_pend_lo_nxt} = w_acc_add;
              w_cnt_nxt   = CW'(MUL_CYCLES);
              w_state_nxt = S_RUN;
            end
            3'b111: begin
              {w_pend_hi_nxt, w_pend_lo_nxt} = w_acc_sub;
              w_cnt_nxt   = CW'(MUL_CYCLES);
              w_state_nxt = S_RUN;
            end
`endif
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = {CW{1'b0}};
        end else if (r_cnt == CW'(1)) begin
          w_hi_nxt    = r_pend_hi;
          w_lo_nxt    = r_pend_lo;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CW{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_pend_hi <= {WIDTH{1'b0}};
      r_pend_lo <= {WIDTH{1'b0}};
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_param.sv
// Directed-vector bench for muldiv_param at default parameters; honours MULDIV_MADD_EN.
module tb_muldiv_param;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   nb;
  int   nd;

  muldiv_param_if #(.WIDTH(32)) u_if ();

  muldiv_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count busy and done cycles until the unit is quiet again.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input int flush_at, output int n_busy, output int n_done);
    n_busy = 0;
    n_done = 0;
    @(negedge clk);
    u_if.op = op; u_if.src_a = a; u_if.src_b = b; u_if.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      u_if.start = 1'b0;
      u_if.flush = 1'b0;
      if (u_if.busy) n_busy++;
      if (u_if.done) n_done++;
      if (!u_if.busy && !u_if.done && (n_busy > 0 || i >= 1)) break;
      if (u_if.busy && n_busy == inj_at) begin
        u_if.op = 3'b001; u_if.src_a = 32'd3; u_if.src_b = 32'd3; u_if.start = 1'b1;
      end
      if (u_if.busy && n_busy == flush_at) u_if.flush = 1'b1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.start = 1'b0; u_if.op = 3'b000; u_if.src_a = 32'd0; u_if.src_b = 32'd0; u_if.flush = 1'b0;
    #12;
    chk("rst_hi", 64'(u_if.hi), 64'h0);
    chk("rst_lo", 64'(u_if.lo), 64'h0);
    chk("rst_busy", 64'(u_if.busy), 64'h0);
    chk("rst_done", 64'(u_if.done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 32'hFFFF_FFFF, 32'h2, -1, -1, nb, nd);
    chk("mult_busy", 64'(nb), 64'd5);
    chk("mult_done", 64'(nd), 64'd1);
    chk("mult_hilo", {u_if.hi, u_if.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'b001, 32'hFFFF_FFFF, 32'h2, -1, -1, nb, nd);
    chk("multu_hilo", {u_if.hi, u_if.lo}, 64'h0000_0001_FFFF_FFFE);

    run_op(3'b010, 32'hFFFF_FFF9, 32'h2, -1, -1, nb, nd);
    chk("div_busy", 64'(nb), 64'd10);
    chk("div_done", 64'(nd), 64'd1);
    chk("div_neg", {u_if.hi, u_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, -1, -1, nb, nd);
    chk("div_negb", {u_if.hi, u_if.lo}, 64'h0000_0001_FFFF_FFFD);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, nb, nd);
    chk("div_ovf", {u_if.hi, u_if.lo}, 64'h0000_0000_8000_0000);
    run_op(3'b011, 32'd100, 32'd7, -1, -1, nb, nd);
    chk("divu", {u_if.hi, u_if.lo}, 64'h0000_0002_0000_000E);

    run_op(3'b011, 32'h64, 32'h0, 3, -1, nb, nd);
    chk("divz_busy", 64'(nb), 64'd10);
    chk("divz_done", 64'(nd), 64'd1);
    chk("divz_hilo", {u_if.hi, u_if.lo}, 64'h0000_0064_FFFF_FFFF);

    run_op(3'b100, 32'h11, 32'h0, -1, -1, nb, nd);
    chk("mthi_busy", 64'(nb), 64'd0);
    run_op(3'b101, 32'h22, 32'h0, -1, -1, nb, nd);
    chk("mtlo_done", 64'(nd), 64'd0);
    chk("mt_hilo", {u_if.hi, u_if.lo}, 64'h0000_0011_0000_0022);
    run_op(3'b010, 32'd9, 32'd3, -1, 4, nb, nd);
    chk("flush_busy", 64'(nb), 64'd4);
    chk("flush_done", 64'(nd), 64'd0);
    chk("flush_hilo", {u_if.hi, u_if.lo}, 64'h0000_0011_0000_0022);

    // Asynchronous reset in the middle of a multiply, checked between clock edges.
    @(negedge clk);
    u_if.op = 3'b000; u_if.src_a = 32'd6; u_if.src_b = 32'd7; u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("pre_rst_busy", 64'(u_if.busy), 64'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(u_if.busy), 64'h0);
    chk("arst_hilo", {u_if.hi, u_if.lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b101, 32'h5, 32'h0, -1, -1, nb, nd);
    chk("post_rst_mtlo", {u_if.hi, u_if.lo}, 64'h0000_0000_0000_0005);

`ifdef MULDIV_MADD_EN
    run_op(3'b101, 32'hFFFF_FFFF, 32'h0, -1, -1, nb, nd);
    run_op(3'b110, 32'h1, 32'h1, -1, -1, nb, nd);
    chk("madd_busy", 64'(nb), 64'd5);
    chk("madd_hilo", {u_if.hi, u_if.lo}, 64'h0000_0001_0000_0000);
    run_op(3'b111, 32'h1, 32'h1, -1, -1, nb, nd);
    chk("msub_hilo", {u_if.hi, u_if.lo}, 64'h0000_0000_FFFF_FFFF);
`else
    run_op(3'b110, 32'h1234, 32'h1, -1, -1, nb, nd);
    chk("madd_off_busy", 64'(nb), 64'd0);
    chk("madd_off_hilo", {u_if.hi, u_if.lo}, 64'h0000_0000_0000_0005);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_param.md
Name: muldiv_param

Overview:
Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair, instantiated in the execute stage of the pipelined core. Accepts one operation per start pulse and models fixed, parameter-set latencies. Drives busy so the hazard unit can stall HI/LO readers and new muldiv ops, and adds flush-abort and a done pulse.

Parameters:
WIDTH, 32, operand, HI and LO width in bits (>=2).
MUL_CYCLES, 5, busy cycles for multiply-class ops (>=1).
DIV_CYCLES, 10, busy cycles for divide-class ops (>=1).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (0 = in reset)
start  input  1  request; sampled on the rising edge of clk
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
src_a  input  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO data)
src_b  input  WIDTH  rt value (divisor / multiplier)
flush  input  1  abort the in-flight op
busy  output  1  op in flight; registered
done  output  1  one-cycle pulse in the cycle after the commit edge; registered
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, pending result cleared. Reset mid-operation discards the op with no commit.
- States: IDLE (busy=0) and RUN (busy=1). A down-counter of width clog2(max(MUL_CYCLES,DIV_CYCLES)+1) holds the remaining cycles.
- Accept: at an edge with start=1 and busy=0, and op not 110/111 with the macro off.
  - MULT/MULTU/DIV/DIVU: the full result is computed from src_a/src_b sampled at that edge and held in a pending register. Counter loads N (MUL_CYCLES or DIV_CYCLES). Enter RUN.
  - MTHI/MTLO: write src_a to hi or lo at that edge. No busy, no done pulse.
- start while busy=1: ignored. The core must stall instead.
- RUN: the counter decrements each edge. At the edge where the counter is 1, the pending result commits to hi/lo, busy falls and done is set for one cycle.
  - busy is high for exactly N cycles.
  - hi/lo keep their old values throughout RUN.
  - A new start in the cycle done=1 is legal.
- MULT: signed 2*WIDTH product; hi = upper half, lo = lower half. MULTU: unsigned.
- DIV: signed, truncating toward zero; lo = quotient, hi = remainder, with the remainder taking the sign of the dividend. DIVU: unsigned.
- Divide by zero (DIV/DIVU): lo = all ones, hi = src_a. busy still lasts DIV_CYCLES.
- Signed overflow (DIV, src_a = -2^(WIDTH-1), src_b = -1): lo = -2^(WIDTH-1), hi = 0.
- Flush:
  - flush=1 with busy=1: at the edge, return to IDLE, counter=0, no commit, no done, hi/lo unchanged. A start in the same cycle is ignored.
  - flush=1 with busy=0: no effect; a start in the same cycle is accepted.
- Ops 110/111 with MULDIV_MADD_EN undefined: no-op. No state change, busy stays 0.

Optional Feature:
MULDIV_MADD_EN.
- Defined: op 110 MADD and 111 MSUB take MUL_CYCLES. The signed product of src_a and src_b is added to (MADD) or subtracted from (MSUB) {hi,lo}, modulo 2^(2*WIDTH).
  - The {hi,lo} value used is the one present at the accept edge.
  - The sum is committed like MULT.
- Undefined: 110/111 are ignored no-ops and no accumulate logic is synthesised.

Test Plan:
All cases use defaults (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
1. MULT a=0xFFFFFFFF b=0x2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE and done pulses once. MULTU with the same operands -> hi=0x1, lo=0xFFFFFFFE.
2. DIV a=0xFFFFFFF9 (-7) b=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIVU a=0x64 b=0 -> after 10 cycles, lo=0xFFFFFFFF, hi=0x64. A second start asserted in cycle 3 of busy is ignored: hi/lo reflect only the first op.
4. Preload hi=0x11, lo=0x22 via MTHI/MTLO (busy stays 0). Then issue DIV a=9 b=3 and assert flush in busy cycle 4 -> busy=0 next cycle, no done, hi=0x11, lo=0x22.
5. Drive reset=0 asynchronously mid-MULT -> hi=lo=0 and busy=0 immediately, without waiting for a clk edge. After reset releases, MTLO a=0x5 -> lo=0x5 at the next edge.
6. (MULDIV_MADD_EN) With hi=0, lo=0xFFFFFFFF, MADD a=1 b=1 -> hi=0x1, lo=0x0 after 5 cycles. Then MSUB a=1 b=1 -> hi=0, lo=0xFFFFFFFF. With the macro undefined, op=110 -> no busy, hi/lo unchanged.
